cruise_control: RTL and testbench

CRUISE_CONTROL -- requirements
Module: cruise_control

---
 rtl/cruise_pkg.sv | 18 +
 rtl/speed_step.sv | 29 ++
 rtl/cruise_control.sv | 191 +++++++++++++++++++
 tb/tb_cruise_control.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cruise_pkg.sv
// rtl/cruise_pkg.sv - shared state encoding and speed constants for the cruise controller
package cruise_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CRUISE = 3'd1,
        ST_ACCEL  = 3'd2,
        ST_COAST  = 3'd3,
        ST_PAUSED = 3'd4
    } state_t;

    localparam int DEF_MAX_SPEED  = 255;
    localparam int DEF_MIN_CRUISE = 45;

    localparam logic [7:0] BRAKE_DEC = 8'd2;
    localparam logic [7:0] STEP_ONE  = 8'd1;

endpackage

// File: rtl/speed_step.sv
// rtl/speed_step.sv - saturating increment/decrement of a speed value between floor and ceiling
module speed_step (
    input  logic [7:0] value,
    input  logic [7:0] delta,
    input  logic       dir,
    input  logic [7:0] floor,
    input  logic [7:0] ceiling,
    output logic [7:0] result
);

    logic [8:0] w_sum;

    assign w_sum = {1'b0, value} + {1'b0, delta};

    // Step up (dir=1) or down (dir=0); a value already at or beyond the limit is held, never pulled back
    always_comb begin
        result = value;
        if (dir) begin
            if (value < ceiling) begin
                result = (w_sum > {1'b0, ceiling}) ? ceiling : w_sum[7:0];
            end
        end else begin
            if (value > floor) begin
                result = ((value - floor) < delta) ? floor : (value - delta);
            end
        end
    end

endmodule

// File: rtl/cruise_control.sv
// rtl/cruise_control.sv - cruise control FSM with a simple modelled vehicle speed
module cruise_control
    import cruise_pkg::*;
#(
    parameter int MAX_SPEED  = DEF_MAX_SPEED,
    parameter int MIN_CRUISE = DEF_MIN_CRUISE
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       throttle,
    input  logic       brake,
    input  logic       set,
    input  logic       resume,
    input  logic       accel,
    input  logic       coast,
    input  logic       cancel,
    input  logic       off,
    output logic [7:0] speed,
    output logic [7:0] cruise_speed,
    output logic       cruise_on,
    output logic [2:0] state
);

    localparam logic [7:0] W_MAX = 8'(MAX_SPEED);
    localparam logic [7:0] W_MIN = 8'(MIN_CRUISE);

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_speed;
    logic [7:0] r_cruise;
    logic       r_cruise_on;

    logic [7:0] w_target;
    logic [7:0] w_next_cruise;
    logic       w_next_on;
    logic       w_set_ok;
    logic       w_disengage;

    logic       w_step_dir;
    logic [7:0] w_step_delta;
    logic [7:0] w_step_floor;
    logic [7:0] w_step_ceil;
    logic [7:0] w_step_result;

    // A set request only counts when the brake is released and the car is fast enough
    assign w_set_ok    = set && !brake && (r_speed >= W_MIN);
    assign w_disengage = brake || cancel;

    // Next state and target; off dominates, then brake/cancel, then set/resume, then accel, then coast
    always_comb begin
        w_next_state = r_state;
        w_target     = r_cruise;
        if (off) begin
            w_next_state = ST_IDLE;
            w_target     = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_set_ok) begin
                        w_next_state = ST_CRUISE;
                        w_target     = r_speed;
                    end
                end
                ST_CRUISE: begin
                    if (w_disengage) begin
                        w_next_state = ST_PAUSED;
                    end else if (w_set_ok) begin
                        w_target = r_speed;
                    end else if (accel) begin
                        w_next_state = ST_ACCEL;
                    end else if (coast) begin
                        w_next_state = ST_COAST;
                    end
                end
                ST_ACCEL: begin
                    if (w_disengage) begin
                        w_next_state = ST_PAUSED;
                    end else if (!accel) begin
                        w_next_state = ST_CRUISE;
                    end
                end
                ST_COAST: begin
                    if (w_disengage) begin
                        w_next_state = ST_PAUSED;
                    end else if (accel) begin
                        w_next_state = ST_ACCEL;
                    end else if (!coast) begin
                        w_next_state = ST_CRUISE;
                    end
                end
                ST_PAUSED: begin
                    if (w_set_ok) begin
                        w_next_state = ST_CRUISE;
                        w_target     = r_speed;
                    end else if (resume && !brake) begin
                        w_next_state = ST_CRUISE;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                    w_target     = '0;
                end
            endcase
        end
    end

    // Speed update follows the behaviour of the state being entered this cycle
    always_comb begin
        w_step_dir   = 1'b0;
        w_step_delta = '0;
        w_step_floor = '0;
        w_step_ceil  = W_MAX;
        case (w_next_state)
            ST_CRUISE: begin
                if (throttle) begin
                    w_step_dir   = 1'b1;
                    w_step_delta = STEP_ONE;
                end else if (r_speed < w_target) begin
                    w_step_dir   = 1'b1;
                    w_step_delta = STEP_ONE;
                end else if (r_speed > w_target) begin
                    w_step_dir   = 1'b0;
                    w_step_delta = STEP_ONE;
                end
            end
            ST_ACCEL: begin
                w_step_dir   = 1'b1;
                w_step_delta = STEP_ONE;
            end
            ST_COAST: begin
                w_step_dir   = 1'b0;
                w_step_delta = STEP_ONE;
                w_step_floor = W_MIN;
            end
            default: begin
                if (brake) begin
                    w_step_dir   = 1'b0;
                    w_step_delta = BRAKE_DEC;
                end else if (throttle) begin
                    w_step_dir   = 1'b1;
                    w_step_delta = STEP_ONE;
                end else begin
                    w_step_dir   = 1'b0;
                    w_step_delta = STEP_ONE;
                end
            end
        endcase
    end

    speed_step u_speed_step (
        .value   (r_speed),
        .delta   (w_step_delta),
        .dir     (w_step_dir),
        .floor   (w_step_floor),
        .ceiling (w_step_ceil),
        .result  (w_step_result)
    );

    // While accelerating or coasting the target follows the car; otherwise it keeps the chosen target
    always_comb begin
        w_next_cruise = w_target;
        if ((w_next_state == ST_ACCEL) || (w_next_state == ST_COAST)) begin
            w_next_cruise = w_step_result;
        end
    end

    assign w_next_on = (w_next_state == ST_CRUISE) ||
                       (w_next_state == ST_ACCEL)  ||
                       (w_next_state == ST_COAST);

    // State, speed, target and engaged flag registers with synchronous clear
    always_ff @(posedge clk) begin
        if (clear) begin
            r_state     <= ST_IDLE;
            r_speed     <= '0;
            r_cruise    <= '0;
            r_cruise_on <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_speed     <= w_step_result;
            r_cruise    <= w_next_cruise;
            r_cruise_on <= w_next_on;
        end
    end

    assign speed        = r_speed;
    assign cruise_speed = r_cruise;
    assign cruise_on    = r_cruise_on;
    assign state        = r_state;

endmodule

// File: tb/tb_cruise_control.sv
// tb/tb_cruise_control.sv - directed table plus randomized reference-model bench for cruise_control
module tb_cruise_control;

    localparam int MAXS = 255;
    localparam int MINC = 45;

    localparam logic [8:0] I_NONE = 9'h000;
    localparam logic [8:0] I_CLR  = 9'h100;
    localparam logic [8:0] I_OFF  = 9'h080;
    localparam logic [8:0] I_BRK  = 9'h040;
    localparam logic [8:0] I_CAN  = 9'h020;
    localparam logic [8:0] I_SET  = 9'h010;
    localparam logic [8:0] I_RES  = 9'h008;
    localparam logic [8:0] I_ACC  = 9'h004;
    localparam logic [8:0] I_CST  = 9'h002;
    localparam logic [8:0] I_THR  = 9'h001;

    typedef struct packed {
        logic clear;
        logic off;
        logic brake;
        logic cancel;
        logic set;
        logic resume;
        logic accel;
        logic coast;
        logic throttle;
    } in_t;

    typedef struct {
        in_t stim;
        int  n;
        int  e_speed;
        int  e_cruise;
        int  e_state;
        int  e_on;
    } vec_t;

    logic       clk = 1'b0;
    logic       clear, throttle, brake, set, resume, accel, coast, cancel, off;
    logic [7:0] speed, cruise_speed;
    logic       cruise_on;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    int m_state  = 0;
    int m_speed  = 0;
    int m_cruise = 0;

    vec_t tbl[$];

    always #5 clk = ~clk;

    cruise_control #(.MAX_SPEED(MAXS), .MIN_CRUISE(MINC)) dut (
        .clk          (clk),
        .clear        (clear),
        .throttle     (throttle),
        .brake        (brake),
        .set          (set),
        .resume       (resume),
        .accel        (accel),
        .coast        (coast),
        .cancel       (cancel),
        .off          (off),
        .speed        (speed),
        .cruise_speed (cruise_speed),
        .cruise_on    (cruise_on),
        .state        (state)
    );

    function automatic int clamp(input int v);
        if (v < 0) return 0;
        if (v > MAXS) return MAXS;
        return v;
    endfunction

    // Reference: states 0..4 = IDLE, CRUISE, ACCEL, COAST, PAUSED
    task automatic model_step(input in_t v);
        int  ns, nc, sp;
        bit  engage;
        if (v.clear) begin
            m_state = 0; m_speed = 0; m_cruise = 0;
            return;
        end
        ns = m_state; nc = m_cruise; sp = m_speed;
        engage = v.set && !v.brake && (m_speed >= MINC);
        if (v.off) begin
            ns = 0; nc = 0;
        end else if ((m_state >= 1 && m_state <= 3) && (v.brake || v.cancel)) begin
            ns = 4;
        end else if (m_state == 0) begin
            if (engage) begin ns = 1; nc = m_speed; end
        end else if (m_state == 4) begin
            if (engage) begin ns = 1; nc = m_speed; end
            else if (v.resume && !v.brake) ns = 1;
        end else if (m_state == 1) begin
            if (engage) nc = m_speed;
            else if (v.accel) ns = 2;
            else if (v.coast) ns = 3;
        end else if (m_state == 2) begin
            if (!v.accel) ns = 1;
        end else if (m_state == 3) begin
            if (v.accel) ns = 2;
            else if (!v.coast) ns = 1;
        end
        case (ns)
            1: begin
                if (v.throttle) sp = clamp(sp + 1);
                else if (nc > sp) sp = sp + 1;
                else if (nc < sp) sp = sp - 1;
            end
            2: begin sp = clamp(sp + 1); nc = sp; end
            3: begin if (sp > MINC) sp = sp - 1; nc = sp; end
            default: begin
                if (v.brake) sp = clamp(sp - 2);
                else if (v.throttle) sp = clamp(sp + 1);
                else sp = clamp(sp - 1);
            end
        endcase
        m_state = ns; m_speed = sp; m_cruise = nc;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic apply(input in_t v);
        clear = v.clear; off = v.off; brake = v.brake; cancel = v.cancel;
        set = v.set; resume = v.resume; accel = v.accel; coast = v.coast;
        throttle = v.throttle;
        @(posedge clk);
        #1;
        model_step(v);
    endtask

    function automatic void add(input logic [8:0] s, input int n, input int es,
                                input int ec, input int est, input int eon);
        vec_t r;
        r.stim = in_t'(s); r.n = n; r.e_speed = es; r.e_cruise = ec;
        r.e_state = est; r.e_on = eon;
        tbl.push_back(r);
    endfunction

    initial begin
        in_t v;
        clear = 0; off = 0; brake = 0; cancel = 0; set = 0;
        resume = 0; accel = 0; coast = 0; throttle = 0;

        add(I_CLR,              1,   0,   0, 0, 0);
        add(I_THR,             50,  50,   0, 0, 0);
        add(I_SET,              1,  50,  50, 1, 1);
        add(I_NONE,             3,  50,  50, 1, 1);
        add(I_BRK,              1,  48,  50, 4, 0);
        add(I_RES,              1,  49,  50, 1, 1);
        add(I_NONE,             1,  50,  50, 1, 1);
        add(I_NONE,             2,  50,  50, 1, 1);
        add(I_ACC | I_CST,      5,  55,  55, 2, 1);
        add(I_NONE,             3,  55,  55, 1, 1);
        add(I_CST,              8,  47,  47, 3, 1);
        add(I_NONE,             1,  47,  47, 1, 1);
        add(I_CST,              5,  45,  45, 3, 1);
        add(I_CAN,              1,  44,  45, 4, 0);
        add(I_RES,              1,  45,  45, 1, 1);
        add(I_ACC,             15,  60,  60, 2, 1);
        add(I_CLR,              1,   0,   0, 0, 0);
        add(I_THR,             30,  30,   0, 0, 0);
        add(I_SET,              1,  29,   0, 0, 0);
        add(I_THR,            300, 255,   0, 0, 0);
        add(I_SET,              1, 255, 255, 1, 1);
        add(I_OFF,              1, 254,   0, 0, 0);
        add(I_RES,              1, 253,   0, 0, 0);
        add(I_BRK,              1, 251,   0, 0, 0);
        add(I_CLR | I_THR | I_ACC | I_SET, 1, 0, 0, 0, 0);
        add(I_BRK,              3,   0,   0, 0, 0);

        foreach (tbl[k]) begin
            for (int j = 0; j < tbl[k].n; j++) apply(tbl[k].stim);
            check($sformatf("vec%0d_speed", k),     {24'd0, speed},        tbl[k].e_speed);
            check($sformatf("vec%0d_cruise", k),    {24'd0, cruise_speed}, tbl[k].e_cruise);
            check($sformatf("vec%0d_state", k),     {29'd0, state},        tbl[k].e_state);
            check($sformatf("vec%0d_cruise_on", k), {31'd0, cruise_on},    tbl[k].e_on);
        end

        for (int i = 0; i < 4000; i++) begin
            v.clear    = ($urandom_range(0, 299) == 0);
            v.off      = ($urandom_range(0, 79) == 0);
            v.brake    = ($urandom_range(0, 9) == 0);
            v.cancel   = ($urandom_range(0, 19) == 0);
            v.set      = ($urandom_range(0, 7) == 0);
            v.resume   = ($urandom_range(0, 7) == 0);
            v.accel    = ($urandom_range(0, 3) == 0);
            v.coast    = ($urandom_range(0, 3) == 0);
            v.throttle = ($urandom_range(0, 99) < 62);
            apply(v);
            check($sformatf("rnd%0d_speed", i),     {24'd0, speed},        m_speed);
            check($sformatf("rnd%0d_cruise", i),    {24'd0, cruise_speed}, m_cruise);
            check($sformatf("rnd%0d_state", i),     {29'd0, state},        m_state);
            check($sformatf("rnd%0d_cruise_on", i), {31'd0, cruise_on},
                  (m_state >= 1 && m_state <= 3) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
